w_mem_scheduler: RTL

Sequencer and port arbiter for the weight memory wrapper. It takes a job descriptor from the HWPE register file and issues the read address stream into the wrapper's CNN or FC read port. Weight preload writes can arrive from the streamer at any time, so the block arbitrates between that write stream and its own read stream, and marks read-data valid and last to the MAC array.

---
 rtl/w_mem_scheduler_pkg.sv | 21 ++
 rtl/w_mem_rr_arb.sv | 44 ++++
 rtl/w_mem_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/w_mem_scheduler_pkg.sv
// Shared definitions for the weight memory scheduler.
//   MODE_CNN : cfg_mode value that selects the CNN read port
//   state_t  : scheduler FSM states
//   grant_t  : identity of the last arbitration winner
package w_mem_scheduler_pkg;

  localparam logic [2:0] MODE_CNN = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic {
    GNT_READ,
    GNT_WRITE
  } grant_t;

endpackage

// File: rtl/w_mem_rr_arb.sv
// Two-requester round-robin arbiter for the single-ported weight memory.
// The winner of a conflict is the side that did not win the previous one.
// Ports:
//   clk, rst       : clock, async active-high reset
//   req_rd, req_wr : read / write requests
//   gnt_rd, gnt_wr : one-hot (or zero) grants, combinational
module w_mem_rr_arb
  import w_mem_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_rd,
  input  logic req_wr,
  output logic gnt_rd,
  output logic gnt_wr
);

  grant_t last_grant;
  logic   conflict;

  assign conflict = req_rd & req_wr;

  always_comb begin
    gnt_rd = 1'b0;
    gnt_wr = 1'b0;
    if (conflict) begin
      if (last_grant == GNT_WRITE) gnt_rd = 1'b1;
      else                         gnt_wr = 1'b1;
    end else begin
      gnt_rd = req_rd;
      gnt_wr = req_wr;
    end
  end

  // Only contested cycles move the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_WRITE;
    end else if (conflict) begin
      last_grant <= gnt_rd ? GNT_READ : GNT_WRITE;
    end
  end

endmodule

// File: rtl/w_mem_scheduler.sv
// Weight memory scheduler: sequences a job's read address stream into the
// CNN or FC read port and arbitrates it against streamer preload writes.
// Ports:
//   clk, reset                       : clock, async active-high reset
//   cfg_start/mode/base_addr/len/repeat : job descriptor, start pulse
//   busy, done                       : job status, one-cycle done pulse
//   wr_valid/ready/addr/data         : streamer write request
//   rd_ready                         : consumer accepts a word
//   rd_valid, rd_last                : read data qualifiers (1 cycle after issue)
//   mem_wr_*_cnn, mem_rd_*, mem_mode : wrapper memory interface
module w_mem_scheduler
  import w_mem_scheduler_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [2:0]        cfg_mode,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_repeat,
  output logic              busy,
  output logic              done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              mem_wr_enable_cnn,
  output logic [ADDR_W-1:0] mem_wr_addr_cnn,
  output logic [DATA_W-1:0] mem_wr_data_cnn,
  output logic              mem_rd_enable,
  output logic [ADDR_W-1:0] mem_rd_addr_cnn,
  output logic [ADDR_W-1:0] mem_rd_addr_fc,
  output logic [2:0]        mem_mode
);

  state_t            state;
  logic [2:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  rep_q;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  pass;
  logic              run;
  logic              arb_gnt_rd;
  logic              arb_gnt_wr;
  logic              rd_grant;
  logic              wr_grant;
  logic              pass_end;
  logic              final_issue;
  logic              sel_cnn;

  assign run = (state == ST_RUN);

  w_mem_rr_arb u_arb (
    .clk    (clk),
    .rst    (reset),
    .req_rd (run & rd_ready),
    .req_wr (wr_valid),
    .gnt_rd (arb_gnt_rd),
    .gnt_wr (arb_gnt_wr)
  );

  assign rd_grant = arb_gnt_rd;
  // The streamer must never see an accept while the block is held in reset.
  assign wr_grant = arb_gnt_wr & ~reset;

  assign pass_end    = (idx == len_q - CNT_W'(1));
  assign final_issue = pass_end && (pass == rep_q - CNT_W'(1));
  assign sel_cnn     = (mode_q == MODE_CNN);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  assign mem_rd_enable   = rd_grant;
  assign mem_rd_addr_cnn = (rd_grant && sel_cnn)  ? addr : '0;
  assign mem_rd_addr_fc  = (rd_grant && !sel_cnn) ? addr : '0;
  assign mem_mode        = mode_q;

  assign wr_ready          = wr_grant;
  assign mem_wr_enable_cnn = wr_grant;
  assign mem_wr_addr_cnn   = wr_grant ? wr_addr : '0;
  assign mem_wr_data_cnn   = wr_grant ? wr_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      mode_q   <= '0;
      base_q   <= '0;
      addr     <= '0;
      len_q    <= '0;
      rep_q    <= '0;
      idx      <= '0;
      pass     <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      // Wrapper read data is registered, so the qualifiers trail issue by one.
      rd_valid <= rd_grant;
      rd_last  <= rd_grant & final_issue;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            mode_q <= cfg_mode;
            base_q <= cfg_base_addr;
            len_q  <= cfg_len;
            rep_q  <= (cfg_repeat == '0) ? CNT_W'(1) : cfg_repeat;
            addr   <= cfg_base_addr;
            idx    <= '0;
            pass   <= '0;
            state  <= (cfg_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_grant) begin
            if (final_issue) begin
              state <= ST_DRAIN;
            end else if (pass_end) begin
              pass <= pass + CNT_W'(1);
              idx  <= '0;
              addr <= base_q;
            end else begin
              idx  <= idx + CNT_W'(1);
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
